ps2_host_receiver: RTL and testbench

Host-side PS/2 receiver: accepts the two-wire device-to-host stream of the kind our PS/2 device transmitter generates. It synchronises and glitch-filters the ps2_clk/ps2_data lines and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Each good byte is presented with a one-cycle valid strobe; bad frames produce one-cycle error strobes. It sits between the board PS/2 pins (or an internal loopback from the transmitter) and the keyboard scancode logic. Receive-only: it never drives either line.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 47 ++++
 rtl/ps2_host_receiver.sv | 150 +++++++++++++++
 tb/tb_ps2_host_receiver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame constants and the
// odd-parity helper used by both the host receiver and the device transmitter.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Parity bit that makes the nine transmitted bits contain an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a glitch filter: the output only follows the
// line after FILTER_LEN consecutive synchronised samples disagree with it.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  localparam int CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the run, so short pulses never reach the output.
  always_comb begin
    sync_d = {sync_q[0], line_in};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_out = filt_q;

endmodule

// File: rtl/ps2_host_receiver.sv
// Host-side PS/2 receiver: filters both lines, deframes 11-bit device frames and
// reports each byte or error with a one-cycle strobe. Never drives the bus.
module ps2_host_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int BW = $clog2(PS2_DATA_BITS);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(PS2_DATA_BITS - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

  logic filt_clk, filt_data;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (ps2_clk),
    .line_out (filt_clk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .reset    (reset),
    .line_in  (ps2_data),
    .line_out (filt_data)
  );

  ps2_state_e                 state_q, state_d;
  logic [BW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0]   shift_q, shift_d;
  logic                       par_q, par_d;
  logic [7:0]                 data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       perr_q, perr_d;
  logic                       ferr_q, ferr_d;
  logic [WW-1:0]              wd_q, wd_d;
  logic                       clk_prev_q, clk_prev_d;
  logic                       fall_q, fall_d;
  logic                       data_bit_q, data_bit_d;

  // The fall strobe and the data sample are registered together so they stay aligned.
  always_comb begin
    clk_prev_d = filt_clk;
    fall_d     = clk_prev_q & ~filt_clk;
    data_bit_d = filt_data;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    wd_d      = (state_q == IDLE || fall_q) ? '0 : wd_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (fall_q && !data_bit_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d[bit_cnt_q] = data_bit_q;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = data_bit_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (!data_bit_q) begin
            ferr_d = 1'b1;
          end else if (par_q == odd_parity(shift_q)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled device abandons the frame; a fall on the same cycle keeps it alive.
    if (state_q != IDLE && !fall_q && wd_q == WD_MAX) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      wd_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      wd_q       <= '0;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      data_bit_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      wd_q       <= wd_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      data_bit_q <= data_bit_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_receiver.sv
// Directed bench for ps2_host_receiver: drives device-style frames, counts the
// result strobes and compares against hand-computed expectations.
module tb_ps2_host_receiver;

  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 20000;
  localparam int HALF           = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  always #5 clk = ~clk;

  ps2_host_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         stop_edge = 0;
  int         valid_cnt = 0;
  int         perr_cnt = 0;
  int         ferr_cnt = 0;
  int         strobe_viol = 0;
  int         valid_cyc = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] vlog [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs received bytes and flags overlapping or back-to-back strobes.
  always @(negedge clk) begin
    if (valid) begin
      vlog[valid_cnt[3:0]] <= data;
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if ((32'(valid) + 32'(parity_err) + 32'(frame_err)) > 1 ||
        (prev_strobe && (valid || parity_err || frame_err)))
      strobe_viol <= strobe_viol + 1;
    prev_strobe <= valid | parity_err | frame_err;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendBit(input logic b, input bit rec, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (6) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF - 9) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b0;
    if (rec) begin
      @(posedge clk);
      stop_edge = cyc;
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop,
                               input int glitch_at);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) sendBit(f[i], (i == 10), (i == glitch_at));
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h00);
    checkOutput("reset_valid", 32'(valid), 32'h0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    applyStimulus(8'h1C, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("f1_valid_count", 32'(valid_cnt), 32'd1);
    checkOutput("f1_data", 32'(data), 32'h1C);
    checkOutput("f1_latency", 32'(valid_cyc - stop_edge - 1), 32'd7);
    checkOutput("f1_no_perr", 32'(perr_cnt), 32'd0);
    checkOutput("f1_no_ferr", 32'(ferr_cnt), 32'd0);
    checkOutput("f1_busy", 32'(busy), 32'h0);

    applyStimulus(8'hF0, 1'b1, 1'b1, -1);
    applyStimulus(8'h1C, 1'b0, 1'b1, -1);
    applyStimulus(8'h00, 1'b1, 1'b1, -1);
    applyStimulus(8'hFF, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("b2b_valid_count", 32'(valid_cnt), 32'd5);
    checkOutput("b2b_byte_F0", 32'(vlog[1]), 32'hF0);
    checkOutput("b2b_byte_1C", 32'(vlog[2]), 32'h1C);
    checkOutput("byte_00", 32'(vlog[3]), 32'h00);
    checkOutput("byte_FF", 32'(vlog[4]), 32'hFF);

    applyStimulus(8'h1C, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("perr_count", 32'(perr_cnt), 32'd1);
    checkOutput("perr_no_valid", 32'(valid_cnt), 32'd5);
    checkOutput("perr_data_held", 32'(data), 32'hFF);
    checkOutput("perr_latency", 32'(cyc - stop_edge - 1 >= 7), 32'd1);

    applyStimulus(8'h1C, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    checkOutput("stop0_ferr", 32'(ferr_cnt), 32'd1);
    checkOutput("stop0_no_perr", 32'(perr_cnt), 32'd1);
    checkOutput("stop0_no_valid", 32'(valid_cnt), 32'd5);
    checkOutput("stop0_data_held", 32'(data), 32'hFF);

    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("stall_busy", 32'(busy), 32'h1);
    repeat (25000) @(negedge clk);
    checkOutput("timeout_ferr", 32'(ferr_cnt), 32'd2);
    checkOutput("timeout_busy", 32'(busy), 32'h0);
    checkOutput("timeout_no_valid", 32'(valid_cnt), 32'd5);
    applyStimulus(8'h5A, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("after_timeout_valid", 32'(valid_cnt), 32'd6);
    checkOutput("after_timeout_data", 32'(data), 32'h5A);

    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle_glitch_busy", 32'(busy), 32'h0);
    checkOutput("idle_glitch_ferr", 32'(ferr_cnt), 32'd2);
    applyStimulus(8'h1C, 1'b0, 1'b1, 4);
    repeat (20) @(negedge clk);
    checkOutput("glitch_frame_valid", 32'(valid_cnt), 32'd7);
    checkOutput("glitch_frame_data", 32'(data), 32'h1C);
    checkOutput("glitch_frame_ferr", 32'(ferr_cnt), 32'd2);

    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    sendBit(1'b1, 1'b0, 1'b0);
    sendBit(1'b0, 1'b0, 1'b0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midframe_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset_data", 32'(data), 32'h00);
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_valid", 32'(valid), 32'h0);
    checkOutput("midreset_frame_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midreset_no_strobes",
                32'(valid_cnt + perr_cnt + ferr_cnt), 32'd10);
    applyStimulus(8'h29, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    checkOutput("after_reset_valid", 32'(valid_cnt), 32'd8);
    checkOutput("after_reset_data", 32'(data), 32'h29);

    checkOutput("strobe_exclusive", 32'(strobe_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
